// File: rtl/l1_tag_assoc.sv
// Set-associative L1 tag array with true-LRU replacement, one lookup and one fill per cycle.
// Optional hit/miss statistics counters are built when L1TAG_STATS_EN is defined.
module l1_tag_assoc #(
    parameter int          ADDR_W     = 32,
    parameter int          LINE_LOG2  = 7,
    parameter int          SET_LOG2   = 5,
    parameter int          WAYS       = 4,
    parameter logic [9:0]  HIT_DELAY  = 10'd1,
    parameter logic [9:0]  MISS_DELAY = 10'd100
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     stall,
    input  logic                     lookup_valid,
    input  logic [ADDR_W-1:0]        Coalesce2L1_o,
    input  logic                     L1TagWrite,
    input  logic [ADDR_W-1:0]        L1TagWriteAddr,
    input  logic                     inval,
    output logic                     result_valid,
    output logic                     L1_HIT,
    output logic [$clog2(WAYS)-1:0]  hit_way,
    output logic [9:0]               Delay,
    output logic [31:0]              hit_count,
    output logic [31:0]              miss_count
);
    localparam int SETS  = 1 << SET_LOG2;
    localparam int TAG_W = ADDR_W - LINE_LOG2 - SET_LOG2;
    localparam int AW    = $clog2(WAYS);

    typedef logic [AW-1:0]    age_t;
    typedef logic [TAG_W-1:0] tag_t;

    logic valid_q [SETS][WAYS];
    logic valid_d [SETS][WAYS];
    tag_t tag_q   [SETS][WAYS];
    tag_t tag_d   [SETS][WAYS];
    age_t age_q   [SETS][WAYS];
    age_t age_d   [SETS][WAYS];

    logic                rv_q, hit_q;
    logic [AW-1:0]       way_q;
    logic [9:0]          dly_q;

    logic [SET_LOG2-1:0] l_idx, f_idx;
    tag_t                l_tag, f_tag;
    logic                lk_acc;
    logic                l_hit, f_match, f_found;
    logic [AW-1:0]       l_way, f_way, f_vic;
    age_t                ref_age;

    assign l_idx  = Coalesce2L1_o[LINE_LOG2+SET_LOG2-1:LINE_LOG2];
    assign l_tag  = Coalesce2L1_o[ADDR_W-1:LINE_LOG2+SET_LOG2];
    assign f_idx  = L1TagWriteAddr[LINE_LOG2+SET_LOG2-1:LINE_LOG2];
    assign f_tag  = L1TagWriteAddr[ADDR_W-1:LINE_LOG2+SET_LOG2];
    assign lk_acc = lookup_valid & ~stall;

    // Both compares look at pre-update state; duplicates cannot exist.
    always_comb begin
        l_hit   = 1'b0;
        l_way   = '0;
        f_match = 1'b0;
        f_way   = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid_q[l_idx][w] && tag_q[l_idx][w] == l_tag) begin
                l_hit = 1'b1;
                l_way = AW'(w);
            end
            if (valid_q[f_idx][w] && tag_q[f_idx][w] == f_tag) begin
                f_match = 1'b1;
                f_way   = AW'(w);
            end
        end
    end

    // Lookup touch first, then fill touch, so a same-set fill ends up MRU.
    always_comb begin
        valid_d = valid_q;
        tag_d   = tag_q;
        age_d   = age_q;
        f_vic   = '0;
        f_found = 1'b0;
        ref_age = '0;
        if (lk_acc && l_hit) begin
            ref_age = age_q[l_idx][l_way];
            for (int w = 0; w < WAYS; w++)
                if (age_d[l_idx][w] < ref_age)
                    age_d[l_idx][w] = age_d[l_idx][w] + age_t'(1);
            age_d[l_idx][l_way] = '0;
        end
        if (L1TagWrite) begin
            for (int w = 0; w < WAYS; w++)
                if (!f_found && !valid_q[f_idx][w]) begin
                    f_found = 1'b1;
                    f_vic   = AW'(w);
                end
            if (!f_found)
                for (int w = 0; w < WAYS; w++)
                    if (age_d[f_idx][w] == age_t'(WAYS-1))
                        f_vic = AW'(w);
            if (f_match)
                f_vic = f_way;
            valid_d[f_idx][f_vic] = 1'b1;
            tag_d[f_idx][f_vic]   = f_tag;
            ref_age = age_d[f_idx][f_vic];
            for (int w = 0; w < WAYS; w++)
                if (age_d[f_idx][w] < ref_age)
                    age_d[f_idx][w] = age_d[f_idx][w] + age_t'(1);
            age_d[f_idx][f_vic] = '0;
        end
        if (inval) begin
            for (int s = 0; s < SETS; s++)
                for (int w = 0; w < WAYS; w++) begin
                    valid_d[s][w] = 1'b0;
                    age_d[s][w]   = age_t'(w);
                end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int s = 0; s < SETS; s++)
                for (int w = 0; w < WAYS; w++) begin
                    valid_q[s][w] <= 1'b0;
                    tag_q[s][w]   <= '0;
                    age_q[s][w]   <= age_t'(w);
                end
        end else begin
            valid_q <= valid_d;
            tag_q   <= tag_d;
            age_q   <= age_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rv_q  <= 1'b0;
            hit_q <= 1'b0;
            way_q <= '0;
            dly_q <= '0;
        end else if (!stall) begin
            rv_q  <= lookup_valid;
            hit_q <= lookup_valid & l_hit;
            way_q <= (lookup_valid & l_hit) ? l_way : '0;
            dly_q <= !lookup_valid ? 10'd0 : (l_hit ? HIT_DELAY : MISS_DELAY);
        end
    end

    assign result_valid = rv_q;
    assign L1_HIT       = hit_q;
    assign hit_way      = way_q;
    assign Delay        = dly_q;

`ifdef L1TAG_STATS_EN
    logic [31:0] hcnt_q, mcnt_q;

    // Counted at the edge that loads the result, so each result counts once.
    always_ff @(posedge clk) begin
        if (reset) begin
            hcnt_q <= '0;
            mcnt_q <= '0;
        end else if (lk_acc) begin
            if (l_hit && hcnt_q != 32'hFFFF_FFFF)
                hcnt_q <= hcnt_q + 32'd1;
            if (!l_hit && mcnt_q != 32'hFFFF_FFFF)
                mcnt_q <= mcnt_q + 32'd1;
        end
    end

    assign hit_count  = hcnt_q;
    assign miss_count = mcnt_q;
`else
    assign hit_count  = 32'd0;
    assign miss_count = 32'd0;
`endif

endmodule

// File: tb/tb_l1_tag_assoc.sv
// Directed testbench for l1_tag_assoc: reset, hit/miss, LRU eviction, stall, invalidate.
module tb_l1_tag_assoc;
    logic        clk = 1'b0;
    logic        reset, stall, lookup_valid, L1TagWrite, inval;
    logic [31:0] Coalesce2L1_o, L1TagWriteAddr;
    logic        result_valid, L1_HIT;
    logic [1:0]  hit_way;
    logic [9:0]  Delay;
    logic [31:0] hit_count, miss_count;

    int checks = 0;
    int errors = 0;
    logic [13:0] got;

    l1_tag_assoc dut (
        .clk            (clk),
        .reset          (reset),
        .stall          (stall),
        .lookup_valid   (lookup_valid),
        .Coalesce2L1_o  (Coalesce2L1_o),
        .L1TagWrite     (L1TagWrite),
        .L1TagWriteAddr (L1TagWriteAddr),
        .inval          (inval),
        .result_valid   (result_valid),
        .L1_HIT         (L1_HIT),
        .hit_way        (hit_way),
        .Delay          (Delay),
        .hit_count      (hit_count),
        .miss_count     (miss_count)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] set21(input int t);
        return (32'(t) << 12) | 32'h0000_0A80;
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
        got = {result_valid, L1_HIT, hit_way, Delay};
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cyc();
        cyc();
        reset = 1'b0;
    endtask

    task automatic fill(input logic [31:0] a);
        L1TagWrite     = 1'b1;
        L1TagWriteAddr = a;
        cyc();
        L1TagWrite     = 1'b0;
    endtask

    task automatic lookup(input logic [31:0] a);
        lookup_valid  = 1'b1;
        Coalesce2L1_o = a;
        cyc();
        lookup_valid  = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (got !== 14'd0 || hit_count !== 32'd0 || miss_count !== 32'd0) begin
            errors++;
            $display("FAIL reset_outputs got %h cnt %0d/%0d exp 0", got, hit_count, miss_count);
        end
        lookup(32'hAAAA_AAAA);
        checks++;
        if (got !== {1'b1, 1'b0, 2'd0, 10'd100}) begin
            errors++;
            $display("FAIL cold_miss got %h exp %h", got, {1'b1, 1'b0, 2'd0, 10'd100});
        end
        cyc();
        checks++;
        if (got !== 14'd0) begin
            errors++;
            $display("FAIL idle_zero got %h exp 0", got);
        end
    endtask

    task automatic test_hit();
        do_reset();
        fill(32'hAAAA_AAAA);
        lookup(32'hAAAA_AAEA);
        checks++;
        if (got !== {1'b1, 1'b1, 2'd0, 10'd1}) begin
            errors++;
            $display("FAIL same_line_hit got %h exp %h", got, {1'b1, 1'b1, 2'd0, 10'd1});
        end
        fill(32'hAAAA_AAAA);
        fill(set21(7));
        lookup(32'hAAAA_AAAA);
        checks++;
        if (got !== {1'b1, 1'b1, 2'd0, 10'd1}) begin
            errors++;
            $display("FAIL no_duplicate got %h exp %h", got, {1'b1, 1'b1, 2'd0, 10'd1});
        end
        lookup(set21(7));
        checks++;
        if (got !== {1'b1, 1'b1, 2'd1, 10'd1}) begin
            errors++;
            $display("FAIL second_way got %h exp %h", got, {1'b1, 1'b1, 2'd1, 10'd1});
        end
    endtask

    task automatic test_evict();
        do_reset();
        for (int t = 1; t <= 5; t++) fill(set21(t));
        lookup(set21(1));
        checks++;
        if (got !== {1'b1, 1'b0, 2'd0, 10'd100}) begin
            errors++;
            $display("FAIL lru_evicted got %h exp %h", got, {1'b1, 1'b0, 2'd0, 10'd100});
        end
        lookup(set21(5));
        checks++;
        if (got !== {1'b1, 1'b1, 2'd0, 10'd1}) begin
            errors++;
            $display("FAIL victim_way0 got %h exp %h", got, {1'b1, 1'b1, 2'd0, 10'd1});
        end
    endtask

    task automatic test_lru_touch();
        do_reset();
        for (int t = 1; t <= 4; t++) fill(set21(t));
        lookup(set21(1));
        checks++;
        if (got !== {1'b1, 1'b1, 2'd0, 10'd1}) begin
            errors++;
            $display("FAIL touch_hit got %h exp %h", got, {1'b1, 1'b1, 2'd0, 10'd1});
        end
        fill(set21(5));
        lookup(set21(5));
        checks++;
        if (got !== {1'b1, 1'b1, 2'd1, 10'd1}) begin
            errors++;
            $display("FAIL victim_way1 got %h exp %h", got, {1'b1, 1'b1, 2'd1, 10'd1});
        end
        lookup(set21(2));
        checks++;
        if (got !== {1'b1, 1'b0, 2'd0, 10'd100}) begin
            errors++;
            $display("FAIL tag2_evicted got %h exp %h", got, {1'b1, 1'b0, 2'd0, 10'd100});
        end
        lookup(set21(1));
        checks++;
        if (got !== {1'b1, 1'b1, 2'd0, 10'd1}) begin
            errors++;
            $display("FAIL tag1_kept got %h exp %h", got, {1'b1, 1'b1, 2'd0, 10'd1});
        end
        do_reset();
        lookup_valid   = 1'b1;
        Coalesce2L1_o  = set21(1);
        L1TagWrite     = 1'b1;
        L1TagWriteAddr = set21(1);
        cyc();
        lookup_valid   = 1'b0;
        L1TagWrite     = 1'b0;
        checks++;
        if (got !== {1'b1, 1'b0, 2'd0, 10'd100}) begin
            errors++;
            $display("FAIL coincident_miss got %h exp %h", got, {1'b1, 1'b0, 2'd0, 10'd100});
        end
        lookup(set21(1));
        checks++;
        if (got !== {1'b1, 1'b1, 2'd0, 10'd1}) begin
            errors++;
            $display("FAIL coincident_then_hit got %h exp %h", got, {1'b1, 1'b1, 2'd0, 10'd1});
        end
    endtask

    task automatic test_stall();
        do_reset();
        fill(32'hAAAA_AAAA);
        lookup(32'hAAAA_AAAA);
        stall          = 1'b1;
        lookup_valid   = 1'b1;
        Coalesce2L1_o  = set21(7);
        L1TagWrite     = 1'b1;
        L1TagWriteAddr = set21(9);
        for (int i = 0; i < 3; i++) begin
            cyc();
            L1TagWrite = 1'b0;
            checks++;
            if (got !== {1'b1, 1'b1, 2'd0, 10'd1}) begin
                errors++;
                $display("FAIL stall_hold%0d got %h exp %h", i, got, {1'b1, 1'b1, 2'd0, 10'd1});
            end
        end
        stall        = 1'b0;
        lookup_valid = 1'b0;
        cyc();
        checks++;
        if (got !== 14'd0) begin
            errors++;
            $display("FAIL stall_release got %h exp 0", got);
        end
        lookup(set21(9));
        checks++;
        if (got !== {1'b1, 1'b1, 2'd1, 10'd1}) begin
            errors++;
            $display("FAIL stall_fill_hit got %h exp %h", got, {1'b1, 1'b1, 2'd1, 10'd1});
        end
    endtask

    task automatic test_inval();
        logic [31:0] exp_h, exp_m;
        do_reset();
        fill(32'hAAAA_AAAA);
        inval          = 1'b1;
        L1TagWrite     = 1'b1;
        L1TagWriteAddr = set21(3);
        lookup_valid   = 1'b1;
        Coalesce2L1_o  = 32'hAAAA_AAAA;
        cyc();
        inval        = 1'b0;
        L1TagWrite   = 1'b0;
        lookup_valid = 1'b0;
        checks++;
        if (got !== {1'b1, 1'b1, 2'd0, 10'd1}) begin
            errors++;
            $display("FAIL inval_pre_state got %h exp %h", got, {1'b1, 1'b1, 2'd0, 10'd1});
        end
        lookup(32'hAAAA_AAAA);
        checks++;
        if (got !== {1'b1, 1'b0, 2'd0, 10'd100}) begin
            errors++;
            $display("FAIL inval_cleared got %h exp %h", got, {1'b1, 1'b0, 2'd0, 10'd100});
        end
        lookup(set21(3));
        checks++;
        if (got !== {1'b1, 1'b0, 2'd0, 10'd100}) begin
            errors++;
            $display("FAIL inval_drop_fill got %h exp %h", got, {1'b1, 1'b0, 2'd0, 10'd100});
        end
`ifdef L1TAG_STATS_EN
        exp_h = 32'd1;
        exp_m = 32'd2;
`else
        exp_h = 32'd0;
        exp_m = 32'd0;
`endif
        checks++;
        if (hit_count !== exp_h || miss_count !== exp_m) begin
            errors++;
            $display("FAIL counters got %0d/%0d exp %0d/%0d", hit_count, miss_count, exp_h, exp_m);
        end
    endtask

    initial begin
        reset          = 1'b1;
        stall          = 1'b0;
        lookup_valid   = 1'b0;
        L1TagWrite     = 1'b0;
        inval          = 1'b0;
        Coalesce2L1_o  = '0;
        L1TagWriteAddr = '0;
        got            = '0;
        test_reset();
        test_hit();
        test_evict();
        test_lru_touch();
        test_stall();
        test_inval();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
